// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types for the branch-predictor in-flight queue
package bp_pkg;

  localparam int ALIAS_W = 6;

  // One in-flight fetch record; eip is kept for debug and mispredict redirect.
  typedef struct packed {
    logic               is_BR;
    logic               prediction;
    logic [ALIAS_W-1:0] br_alias;
    logic [31:0]        eip;
  } bp_entry_t;

endpackage

// File: rtl/bp_queue_ram.sv
// rtl/bp_queue_ram.sv - DEPTH-entry register array, one write port, one async read port
module bp_queue_ram
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  bp_entry_t        wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output bp_entry_t        rdata_o
);

  // Contents need no reset: only entries between head and tail are ever read.
  bp_entry_t mem_q [DEPTH];

  // Write the tail entry on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bp_inflight_queue.sv
// rtl/bp_inflight_queue.sv - in-order queue of gshare predictions feeding back resolved outcomes
module bp_inflight_queue #(
  parameter int DEPTH   = 8,
  parameter int ALIAS_W = bp_pkg::ALIAS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic                     enq_is_BR,
  input  logic                     enq_prediction,
  input  logic [ALIAS_W-1:0]       enq_alias,
  input  logic [31:0]              enq_eip,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     ext_flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ALIAS_W-1:0]       prev_BR_alias,
  output logic                     prev_BR_result,
  output logic                     prev_is_BR,
  output logic                     mispredict,
  output logic [31:0]              redirect_eip
);

  import bp_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [ALIAS_W-1:0] alias_q, alias_d;
  logic               result_q, result_d;
  logic               is_br_q, is_br_d;
  logic               mispred_q, mispred_d;
  logic [31:0]        redir_q, redir_d;

  bp_entry_t wr_entry;
  bp_entry_t head_entry;

  logic enq_ok;
  logic res_ok;
  logic res_mispred;
  logic flush;
  logic ram_we;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign prev_BR_alias  = alias_q;
  assign prev_BR_result = result_q;
  assign prev_is_BR     = is_br_q;
  assign mispredict     = mispred_q;
  assign redirect_eip   = redir_q;

  assign wr_entry = '{is_BR:      enq_is_BR,
                      prediction: enq_prediction,
                      br_alias:   enq_alias,
                      eip:        enq_eip};

  // Full blocks enqueue even when a resolve frees a slot this cycle.
  assign enq_ok      = enq_valid && !full;
  assign res_ok      = res_valid && !empty;
  assign res_mispred = res_ok && head_entry.is_BR && (head_entry.prediction != res_taken);
  assign flush       = res_mispred || ext_flush;
  // An enqueue that coincides with a flush is younger than the flush point and is dropped.
  assign ram_we      = enq_ok && !flush;

  bp_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (head_entry)
  );

  // Pointer/occupancy update and registered resolution report.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    alias_d   = '0;
    result_d  = 1'b0;
    is_br_d   = 1'b0;
    mispred_d = 1'b0;
    redir_d   = '0;

    if (flush) begin
      // Discard everything: the dropped enqueue leaves tail where it is.
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq_ok) tail_d = tail_q + PTR_W'(1);
      if (res_ok) head_d = head_q + PTR_W'(1);
      if (enq_ok && !res_ok) count_d = count_q + (PTR_W+1)'(1);
      if (!enq_ok && res_ok) count_d = count_q - (PTR_W+1)'(1);
    end

    if (res_ok) begin
      alias_d   = head_entry.br_alias;
      result_d  = head_entry.is_BR & res_taken;
      is_br_d   = head_entry.is_BR;
      mispred_d = res_mispred;
      redir_d   = head_entry.eip;
    end
  end

  // State registers; reset overrides any concurrent enqueue or resolution.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      alias_q   <= '0;
      result_q  <= 1'b0;
      is_br_q   <= 1'b0;
      mispred_q <= 1'b0;
      redir_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      alias_q   <= alias_d;
      result_q  <= result_d;
      is_br_q   <= is_br_d;
      mispred_q <= mispred_d;
      redir_q   <= redir_d;
    end
  end

endmodule

// File: tb/tb_bp_inflight_queue.sv
// tb/tb_bp_inflight_queue.sv - directed self-checking bench for bp_inflight_queue
module tb_bp_inflight_queue;

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic        enq_is_BR;
  logic        enq_prediction;
  logic [5:0]  enq_alias;
  logic [31:0] enq_eip;
  logic        res_valid;
  logic        res_taken;
  logic        ext_flush;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic [5:0]  prev_BR_alias;
  logic        prev_BR_result;
  logic        prev_is_BR;
  logic        mispredict;
  logic [31:0] redirect_eip;

  int n_vec;
  int n_err;

  bp_inflight_queue #(
    .DEPTH   (8),
    .ALIAS_W (6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enq_valid      (enq_valid),
    .enq_is_BR      (enq_is_BR),
    .enq_prediction (enq_prediction),
    .enq_alias      (enq_alias),
    .enq_eip        (enq_eip),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .ext_flush      (ext_flush),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .prev_BR_alias  (prev_BR_alias),
    .prev_BR_result (prev_BR_result),
    .prev_is_BR     (prev_is_BR),
    .mispredict     (mispredict),
    .redirect_eip   (redirect_eip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic br, input logic pred,
                         input logic [5:0] al, input logic [31:0] eip);
    enq_valid      = v;
    enq_is_BR      = br;
    enq_prediction = pred;
    enq_alias      = al;
    enq_eip        = eip;
  endtask

  task automatic set_res(input logic v, input logic taken);
    res_valid = v;
    res_taken = taken;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_isbr"}, 64'(prev_is_BR), 64'd0);
    chk({tag, "_res"},  64'(prev_BR_result), 64'd0);
    chk({tag, "_mis"},  64'(mispredict), 64'd0);
    chk({tag, "_alias"}, 64'(prev_BR_alias), 64'd0);
    chk({tag, "_redir"}, 64'(redirect_eip), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    ext_flush = 1'b0;
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    set_res(1'b0, 1'b0);

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk_idle("rst");

    // Single correctly predicted taken branch.
    set_enq(1'b1, 1'b1, 1'b1, 6'h15, 32'h0000_0100);
    tick();
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    chk("one_count1", 64'(count), 64'd1);
    set_res(1'b1, 1'b1);
    tick();
    set_res(1'b0, 1'b0);
    chk("one_isbr",  64'(prev_is_BR), 64'd1);
    chk("one_res",   64'(prev_BR_result), 64'd1);
    chk("one_alias", 64'(prev_BR_alias), 64'h15);
    chk("one_mis",   64'(mispredict), 64'd0);
    chk("one_count0", 64'(count), 64'd0);
    tick();
    chk_idle("one_after");

    // Fill to DEPTH, drop a ninth, then drain in order across the wrap.
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b1, 1'b1, 1'b1, 6'(i), 32'h2000 + 32'(i));
      tick();
    end
    set_enq(1'b1, 1'b1, 1'b1, 6'h3F, 32'hDEAD);
    tick();
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    chk("fill_full",  64'(full),  64'd1);
    chk("fill_count", 64'(count), 64'd8);
    set_res(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain_alias%0d", i), 64'(prev_BR_alias), 64'(i));
      chk($sformatf("drain_eip%0d", i), 64'(redirect_eip), 64'h2000 + 64'(i));
      chk($sformatf("drain_mis%0d", i), 64'(mispredict), 64'd0);
    end
    set_res(1'b0, 1'b0);
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_count", 64'(count), 64'd0);

    // Mispredict on the oldest of three flushes the younger two.
    set_enq(1'b1, 1'b1, 1'b1, 6'h01, 32'h0000_1000);
    tick();
    set_enq(1'b1, 1'b1, 1'b0, 6'h02, 32'h0000_1004);
    tick();
    set_enq(1'b1, 1'b0, 1'b0, 6'h03, 32'h0000_1008);
    tick();
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    chk("mis_pre_count", 64'(count), 64'd3);
    set_res(1'b1, 1'b0);
    tick();
    chk("mis_flag",  64'(mispredict), 64'd1);
    chk("mis_redir", 64'(redirect_eip), 64'h1000);
    chk("mis_isbr",  64'(prev_is_BR), 64'd1);
    chk("mis_res",   64'(prev_BR_result), 64'd0);
    chk("mis_count", 64'(count), 64'd0);
    chk("mis_empty", 64'(empty), 64'd1);
    tick();
    set_res(1'b0, 1'b0);
    chk_idle("mis_empty_res");
    chk("mis_empty_count", 64'(count), 64'd0);

    // Steady state at count 4 with enqueue and resolve every cycle.
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 1'b1, 1'(i), 6'h20 + 6'(i), 32'h3000 + 32'(i));
      tick();
    end
    chk("ss_count_pre", 64'(count), 64'd4);
    for (int k = 0; k < 20; k++) begin
      set_enq(1'b1, 1'b1, 1'(k + 4), 6'h24 + 6'(k), 32'h3004 + 32'(k));
      set_res(1'b1, 1'(k));
      tick();
      chk($sformatf("ss_count%0d", k), 64'(count), 64'd4);
      chk($sformatf("ss_alias%0d", k), 64'(prev_BR_alias), 64'h20 + 64'(k));
      chk($sformatf("ss_mis%0d", k), 64'(mispredict), 64'd0);
    end
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    for (int k = 20; k < 24; k++) begin
      set_res(1'b1, 1'(k));
      tick();
      chk($sformatf("ss_tail_alias%0d", k), 64'(prev_BR_alias), 64'h20 + 64'(k));
    end
    set_res(1'b0, 1'b0);
    chk("ss_drained", 64'(count), 64'd0);

    // Non-branch resolve reports no branch update.
    set_enq(1'b1, 1'b0, 1'b0, 6'h2A, 32'h0000_4000);
    tick();
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    set_res(1'b1, 1'b1);
    tick();
    set_res(1'b0, 1'b0);
    chk("nb_isbr",  64'(prev_is_BR), 64'd0);
    chk("nb_res",   64'(prev_BR_result), 64'd0);
    chk("nb_mis",   64'(mispredict), 64'd0);
    chk("nb_alias", 64'(prev_BR_alias), 64'h2A);
    chk("nb_count", 64'(count), 64'd0);

    // External flush with a same-cycle mispredicting resolve.
    set_enq(1'b1, 1'b1, 1'b0, 6'h11, 32'h0000_5000);
    tick();
    set_enq(1'b1, 1'b1, 1'b0, 6'h12, 32'h0000_5004);
    tick();
    set_enq(1'b1, 1'b1, 1'b0, 6'h13, 32'h0000_5008);
    set_res(1'b1, 1'b1);
    ext_flush = 1'b1;
    tick();
    ext_flush = 1'b0;
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    set_res(1'b0, 1'b0);
    chk("xf_mis",   64'(mispredict), 64'd1);
    chk("xf_redir", 64'(redirect_eip), 64'h5000);
    chk("xf_alias", 64'(prev_BR_alias), 64'h11);
    chk("xf_count", 64'(count), 64'd0);

    // Reset mid-stream with five entries beats a concurrent enqueue and resolve.
    for (int i = 0; i < 5; i++) begin
      set_enq(1'b1, 1'b1, 1'b1, 6'h30 + 6'(i), 32'h6000 + 32'(i));
      tick();
    end
    chk("mr_count_pre", 64'(count), 64'd5);
    set_enq(1'b1, 1'b1, 1'b1, 6'h3E, 32'h6FFF);
    set_res(1'b1, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_enq(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    set_res(1'b0, 1'b0);
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_empty", 64'(empty), 64'd1);
    chk_idle("mr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_inflight_queue.md
Name: bp_inflight_queue

Overview:
- Sits directly downstream of bp_gshare.
- Captures each fetched instruction's prediction, BP_alias and is-branch flag in an in-order queue.
- On in-order resolution from execute, pops the head entry and drives bp_gshare's update inputs (prev_BR_alias, prev_BR_result, prev_is_BR).
- Flags mispredictions and flushes all younger in-flight entries.

Parameters:
- DEPTH, 8, number of in-flight entries; power of two, 2..64.
- ALIAS_W, 6, width of BP_alias / prev_BR_alias; must match bp_gshare.
- PTR_W, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-low reset.
- enq_valid  in  1  fetch pushes one entry this cycle.
- enq_is_BR  in  1  entry is a conditional branch.
- enq_prediction  in  1  bp_gshare prediction for this entry.
- enq_alias  in  ALIAS_W  bp_gshare BP_alias for this entry.
- enq_eip  in  32  fetch eip; carried for debug and flush redirect.
- res_valid  in  1  execute resolves the oldest entry this cycle.
- res_taken  in  1  actual branch outcome; ignored for non-branches.
- ext_flush  in  1  external pipeline flush; clears the queue.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  PTR_W+1  occupancy.
- prev_BR_alias  out  ALIAS_W  registered alias of the resolved entry, to bp_gshare.
- prev_BR_result  out  1  registered outcome, to bp_gshare.
- prev_is_BR  out  1  registered 1-cycle pulse: a branch was resolved; update enable for bp_gshare.
- mispredict  out  1  registered 1-cycle pulse.
- redirect_eip  out  32  eip of the mispredicted entry; valid with mispredict.

Behaviour:
- Reset (reset==0 at posedge):
  - head, tail and count go to 0.
  - All outputs go to 0; empty=1.
  - Queue contents are don't-care.
  - Reset has priority over every other input, including a mid-operation enqueue or resolution.
- Enqueue: enq_valid && !full writes {is_BR, prediction, alias, eip} at tail; tail wraps modulo DEPTH.
  - enq_valid while full is dropped silently. There is no same-cycle bypass: full blocks enqueue even if res_valid is high.
- Resolve: res_valid && !empty pops the head; head wraps modulo DEPTH. Next cycle (1-cycle latency):
  - prev_BR_alias = head.alias.
  - prev_BR_result = head.is_BR & res_taken.
  - prev_is_BR = head.is_BR.
  - mispredict = head.is_BR & (head.prediction != res_taken).
  - redirect_eip = head.eip.
- res_valid while empty is ignored; the update outputs are 0 next cycle.
- Outputs are pulses: they are 0 in any cycle following no valid resolution. prev_BR_alias and redirect_eip are 0 when not valid.
- Mispredict flush: in the cycle a mispredicting resolution is accepted, all remaining entries are discarded.
  - head = tail = next tail, count = 0.
  - A same-cycle enqueue is also dropped.
- ext_flush clears the queue the same way.
  - A same-cycle res_valid is still accepted and reported. Its mispredict is reported, but the flush action is already implied.
- Simultaneous enqueue and resolve without mispredict: both occur, count unchanged.
- count arithmetic is PTR_W+1 bits, so DEPTH is representable; full and empty derive from count.

Decomposition:
- Shared package bp_pkg:
  - ALIAS_W constant.
  - bp_entry_t struct {is_BR, prediction, alias[ALIAS_W-1:0], eip[31:0]}.
- One natural sub-module: bp_queue_ram, a DEPTH x entry register array with one write port and one asynchronous read port.
- Pointer and count control plus the output registers stay in the top module.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> empty=1, count=0, all update outputs 0.
- Enqueue alias 0x15 (is_BR=1, pred=1), resolve with res_taken=1 -> next cycle prev_is_BR=1, prev_BR_result=1, prev_BR_alias=0x15, mispredict=0, count returns to 0.
- Fill 8 entries (aliases 0x00..0x07), then a 9th enqueue -> full=1, count=8, 9th dropped. Then 8 resolves return aliases 0x00..0x07 in order, confirming wrap.
- Enqueue 3 entries, first with pred=1. Resolve first with res_taken=0 -> mispredict=1, redirect_eip = first eip, count=0. Subsequent res_valid -> outputs 0.
- Steady state at count=4 with enqueue and non-mispredict resolve every cycle for 20 cycles -> count stays 4, aliases emerge in FIFO order across pointer wrap.
- Non-branch resolve (enq_is_BR=0, pred=0, res_taken=1) -> prev_is_BR=0, prev_BR_result=0, mispredict=0. Also assert reset mid-stream with 5 entries -> next cycle count=0 and outputs 0.
